// File: rtl/maze_escaper.sv
// maze_escaper
//   Hardware maze solver. Starting from the single opening in the top row,
//   the walker follows the right-hand wall one cell per clock until it lands
//   in the bottom row. It keeps a bit-map of the cells on the current route.
//   When the walker steps back onto a cell that is already marked, the cell
//   it just left is unmarked. This prunes dead-end excursions, so only the
//   solution path remains marked.
//
// Ports
//   clk   : clock
//   rst   : synchronous, active-high reset; restarts the search
//   maze  : maze[y][x] = 1 is a wall, 0 is open; held static after reset
//   px/py : current walker column / row
//   done  : high once the walker reaches row size-1; held until rst
//   path  : path[y][x] = 1 marks a cell on the current route

module maze_escaper #(
    parameter int size = 5,
    parameter int N    = $clog2(size)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] maze [size-1:0],
    output logic [N-1:0]    px,
    output logic [N-1:0]    py,
    output logic            done,
    output logic [size-1:0] path [size-1:0]
);

    typedef enum logic [1:0] {
        S_FIND,
        S_WALK,
        S_DONE,
        S_FAIL
    } state_t;

    // Headings are numbered clockwise, so "turn right" is +1 modulo 4.
    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [N-1:0] EDGE = N'(size - 1);

    state_t          state, state_d;
    logic [1:0]      hd, hd_d;
    logic [N-1:0]    sx, sx_d;
    logic [N-1:0]    px_d, py_d;
    logic            done_d;
    logic [size-1:0] path_d [size-1:0];

    logic [N-1:0]    yn, ys, xw, xe;
    logic [3:0]      blk;
    logic [1:0]      cand [4];
    logic            mv_ok;
    logic [1:0]      mv_dir;
    logic [N-1:0]    nx, ny;
    logic [N-1:0]    fx;
    logic            found;

    // Neighbour coordinates are clamped at the border. The clamped value is
    // never used for a move, because the same border test marks that
    // direction as blocked. Clamping keeps every maze lookup in range.
    always_comb begin
        yn = (py == '0)   ? py : py - N'(1);
        ys = (py == EDGE) ? py : py + N'(1);
        xw = (px == '0)   ? px : px - N'(1);
        xe = (px == EDGE) ? px : px + N'(1);

        blk[DIR_N] = (py == '0)   || maze[yn][px];
        blk[DIR_S] = (py == EDGE) || maze[ys][px];
        blk[DIR_W] = (px == '0)   || maze[py][xw];
        blk[DIR_E] = (px == EDGE) || maze[py][xe];
    end

    // Right-hand rule: try right, straight, left, then back. The loop runs
    // from lowest to highest priority, so the highest-priority open
    // direction is the last one written.
    always_comb begin
        cand[0] = hd + 2'd1;
        cand[1] = hd;
        cand[2] = hd + 2'd3;
        cand[3] = hd + 2'd2;

        mv_ok  = 1'b0;
        mv_dir = hd;
        for (int k = 3; k >= 0; k--) begin
            if (!blk[cand[k]]) begin
                mv_ok  = 1'b1;
                mv_dir = cand[k];
            end
        end

        nx = px;
        ny = py;
        case (mv_dir)
            DIR_N:   ny = yn;
            DIR_E:   nx = xe;
            DIR_S:   ny = ys;
            default: nx = xw;
        endcase
    end

    // Entrance search: the lowest open column of row 0. Scanning downward
    // means the last match written is the lowest column.
    always_comb begin
        fx    = '0;
        found = 1'b0;
        for (int i = size - 1; i >= 0; i--) begin
            if (!maze[0][i]) begin
                fx    = N'(i);
                found = 1'b1;
            end
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d = state;
        hd_d    = hd;
        sx_d    = sx;
        px_d    = px;
        py_d    = py;
        done_d  = done;
        path_d  = path;

        case (state)
            S_FIND: begin
                if (found) begin
                    px_d          = fx;
                    py_d          = '0;
                    path_d[0][fx] = 1'b1;
                    hd_d          = DIR_S;
                    sx_d          = fx;
                    state_d       = S_WALK;
                end else begin
                    state_d = S_FAIL;
                end
            end

            S_WALK: begin
                if (!mv_ok) begin
                    // Enclosed on all four sides.
                    state_d = S_FAIL;
                end else begin
                    px_d = nx;
                    py_d = ny;
                    hd_d = mv_dir;
                    // Stepping onto a marked cell means we are backing out
                    // of a dead end, so unmark the cell being left.
                    if (path[ny][nx]) begin
                        path_d[py][px] = 1'b0;
                    end else begin
                        path_d[ny][nx] = 1'b1;
                    end

                    if (ny == EDGE) begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else if (ny == '0 && nx == sx && mv_dir == DIR_N) begin
                        // The wall-follower has gone all the way round and
                        // come back to the entrance: there is no exit.
                        state_d = S_FAIL;
                    end
                end
            end

            default: ;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_FIND;
            hd    <= DIR_S;
            sx    <= '0;
            px    <= '0;
            py    <= '0;
            done  <= 1'b0;
            for (int i = 0; i < size; i++) begin
                path[i] <= '0;
            end
        end else begin
            state <= state_d;
            hd    <= hd_d;
            sx    <= sx_d;
            px    <= px_d;
            py    <= py_d;
            done  <= done_d;
            path  <= path_d;
        end
    end

endmodule

// File: tb/tb_maze_escaper.sv
// Testbench for maze_escaper (size = 5). Expected walker positions are
// queued when a scenario starts. Each cycle, one entry is popped and
// compared with the DUT outputs on the falling edge.

module tb_maze_escaper;

    localparam int SZ = 5;
    localparam int NW = $clog2(SZ);

    typedef struct {
        logic [NW-1:0] x;
        logic [NW-1:0] y;
        logic          d;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic [SZ-1:0] maze [SZ-1:0];
    logic [NW-1:0] px;
    logic [NW-1:0] py;
    logic          done;
    logic [SZ-1:0] path [SZ-1:0];

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    maze_escaper #(.size(SZ)) dut (
        .clk  (clk),
        .rst  (rst),
        .maze (maze),
        .px   (px),
        .py   (py),
        .done (done),
        .path (path)
    );

    always #5 clk = ~clk;

    task automatic set_maze(input logic [SZ-1:0] r0, input logic [SZ-1:0] r1,
                            input logic [SZ-1:0] r2, input logic [SZ-1:0] r3,
                            input logic [SZ-1:0] r4);
        maze[0] = r0;
        maze[1] = r1;
        maze[2] = r2;
        maze[3] = r3;
        maze[4] = r4;
    endtask

    task automatic push(input int x, input int y, input logic d);
        exp_t e;
        e.x = NW'(x);
        e.y = NW'(y);
        e.d = d;
        sb.push_back(e);
    endtask

    // Leaves the bench on a falling edge with rst just released. The next
    // rising edge is the FIND cycle.
    task automatic start();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_maze(5'b11011, 5'b10001, 5'b11101, 5'b10001, 5'b11101);
        @(posedge clk);
        @(negedge clk);
        checks++;
        if ({px, py, done} !== {NW'(0), NW'(0), 1'b0}) begin
            errors++;
            $display("FAIL reset_state px=%0d py=%0d done=%0d required 0 0 0", px, py, done);
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== '0) begin
                errors++;
                $display("FAIL reset_path row=%0d got=%b required=00000", y, path[y]);
            end
        end
    endtask

    task automatic test_corridor();
        exp_t e;
        set_maze(5'b11011, 5'b11011, 5'b11011, 5'b11011, 5'b11011);
        start();
        for (int i = 0; i < SZ; i++) push(2, i, i == SZ - 1);
        push(2, 4, 1'b1);
        push(2, 4, 1'b1);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL corridor_pos px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== 5'b00100) begin
                errors++;
                $display("FAIL corridor_path row=%0d got=%b required=00100", y, path[y]);
            end
        end
    endtask

    task automatic test_turning();
        exp_t          e;
        logic [SZ-1:0] ep [SZ];
        ep = '{5'b00100, 5'b00110, 5'b00010, 5'b00010, 5'b00010};
        set_maze(5'b11011, 5'b10001, 5'b11101, 5'b10001, 5'b11101);
        start();
        push(2, 0, 0); push(2, 1, 0); push(1, 1, 0);
        push(1, 2, 0); push(1, 3, 0); push(1, 4, 1);
        push(1, 4, 1); push(1, 4, 1);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL turning_pos px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== ep[y]) begin
                errors++;
                $display("FAIL turning_path row=%0d got=%b required=%b", y, path[y], ep[y]);
            end
        end
    endtask

    task automatic test_dead_end();
        logic [SZ-1:0] ep [SZ];
        int            c;
        ep = '{5'b00100, 5'b00110, 5'b00010, 5'b00010, 5'b00010};
        set_maze(5'b11011, 5'b10001, 5'b10101, 5'b11101, 5'b11101);
        start();
        c = 0;
        while (c < 40 && done !== 1'b1) begin
            @(negedge clk);
            c++;
        end
        checks++;
        if ({px, py, done} !== {NW'(1), NW'(4), 1'b1}) begin
            errors++;
            $display("FAIL dead_end_exit px=%0d py=%0d done=%0d required 1 4 1 (cycles=%0d)",
                     px, py, done, c);
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== ep[y]) begin
                errors++;
                $display("FAIL dead_end_path row=%0d got=%b required=%b", y, path[y], ep[y]);
            end
            checks++;
            if ((path[y] & maze[y]) !== '0) begin
                errors++;
                $display("FAIL dead_end_wall row=%0d overlap=%b required=00000", y, path[y] & maze[y]);
            end
        end
    endtask

    // A west spur at (1,1) that the walker must enter and back out of.
    task automatic test_retrace();
        exp_t          e;
        logic [SZ-1:0] ep [SZ];
        ep = '{5'b00100, 5'b01100, 5'b01000, 5'b01000, 5'b01000};
        set_maze(5'b11011, 5'b10001, 5'b10111, 5'b10111, 5'b10111);
        start();
        push(2, 0, 0); push(2, 1, 0); push(1, 1, 0); push(2, 1, 0);
        push(3, 1, 0); push(3, 2, 0); push(3, 3, 0); push(3, 4, 1);
        push(3, 4, 1);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL retrace_pos px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== ep[y]) begin
                errors++;
                $display("FAIL retrace_path row=%0d got=%b required=%b", y, path[y], ep[y]);
            end
        end
    endtask

    task automatic test_no_exit();
        exp_t e;
        set_maze(5'b11011, 5'b10001, 5'b11101, 5'b10001, 5'b11111);
        start();
        push(2, 0, 0); push(2, 1, 0); push(1, 1, 0); push(1, 2, 0);
        push(1, 3, 0); push(2, 3, 0); push(3, 3, 0); push(2, 3, 0);
        push(1, 3, 0); push(1, 2, 0); push(1, 1, 0); push(2, 1, 0);
        push(3, 1, 0); push(2, 1, 0); push(2, 0, 0);
        for (int i = 0; i < 4; i++) push(2, 0, 0);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL no_exit_pos px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== ((y == 0) ? 5'b00100 : 5'b00000)) begin
                errors++;
                $display("FAIL no_exit_path row=%0d got=%b", y, path[y]);
            end
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        set_maze(5'b11011, 5'b10001, 5'b11101, 5'b10001, 5'b11101);
        start();
        push(2, 0, 0); push(2, 1, 0); push(1, 1, 0);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL midrst_pre px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({px, py, done} !== {NW'(0), NW'(0), 1'b0}) begin
            errors++;
            $display("FAIL midrst_state px=%0d py=%0d done=%0d required 0 0 0", px, py, done);
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== '0) begin
                errors++;
                $display("FAIL midrst_path row=%0d got=%b required=00000", y, path[y]);
            end
        end
        rst = 1'b0;
        push(2, 0, 0); push(2, 1, 0); push(1, 1, 0);
        push(1, 2, 0); push(1, 3, 0); push(1, 4, 1);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL midrst_rerun px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
    endtask

    task automatic test_no_entrance();
        exp_t e;
        set_maze(5'b11111, 5'b10001, 5'b11101, 5'b10001, 5'b11101);
        start();
        for (int i = 0; i < 8; i++) push(0, 0, 0);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL no_entrance_pos px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
        for (int y = 0; y < SZ; y++) begin
            checks++;
            if (path[y] !== '0) begin
                errors++;
                $display("FAIL no_entrance_path row=%0d got=%b required=00000", y, path[y]);
            end
        end
    endtask

    task automatic test_enclosed();
        exp_t e;
        set_maze(5'b11011, 5'b11111, 5'b11101, 5'b10001, 5'b11101);
        start();
        for (int i = 0; i < 6; i++) push(2, 0, 0);
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({px, py, done} !== {e.x, e.y, e.d}) begin
                errors++;
                $display("FAIL enclosed_pos px=%0d py=%0d done=%0d required %0d %0d %0d",
                         px, py, done, e.x, e.y, e.d);
            end
        end
        checks++;
        if (path[0] !== 5'b00100) begin
            errors++;
            $display("FAIL enclosed_path row=0 got=%b required=00100", path[0]);
        end
    endtask

    initial begin
        rst = 1'b1;
        test_reset();
        test_corridor();
        test_turning();
        test_dead_end();
        test_retrace();
        test_no_exit();
        test_reset_mid();
        test_no_entrance();
        test_enclosed();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
